// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Instruction supply for the decode stage. Owns the fetch PC, issues reads
//   to a synchronous instruction ROM (one-cycle read latency), and buffers the
//   returned words in a small prefetch FIFO that decode drains through a
//   valid/ready handshake. A redirect flushes the FIFO, drops the in-flight
//   word and restarts fetch at the new target.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   imem_en        ROM read strobe
//   imem_addr      ROM byte address (word aligned)
//   imem_rdata     ROM data, valid the cycle after imem_en
//   instr          instruction to decode (NOP_WORD when empty)
//   instr_pc       byte address of instr (holds last value when empty)
//   instr_valid    instr/instr_pc are live
//   instr_ready    decode accepts this cycle
//   redirect_valid branch/jump taken: flush and refetch
//   redirect_pc    new fetch address (bits [1:0] forced to 0)
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]             pc_q, pc_d;
  logic                    infl_q;
  logic [31:0]             infl_addr_q;
  logic [DEPTH-1:0][31:0]  data_q, addr_q;
  logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [31:0]             last_pc_q;

  logic [CW:0] occ;
  logic        issue, push, pop;

  // Credit = queued words plus the word still in the ROM pipe, taken before
  // this cycle's pop so a full FIFO can never be overrun by a late response.
  assign occ   = {1'b0, cnt_q} + {{CW{1'b0}}, infl_q};
  assign issue = reset && !redirect_valid && (occ < DEPTH_W);
  // A response arriving in a redirect cycle is dropped by the flush branch.
  assign push  = infl_q;
  assign pop   = instr_valid && instr_ready;

  assign imem_en     = issue;
  assign imem_addr   = pc_q;
  assign instr_valid = (cnt_q != '0);
  assign instr       = instr_valid ? data_q[rd_ptr_q] : NOP_WORD;
  assign instr_pc    = instr_valid ? addr_q[rd_ptr_q] : last_pc_q;

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (redirect_valid) begin
      pc_d  = redirect_pc & ~32'h3;
      cnt_d = '0;
    end else if (issue) begin
      pc_d = pc_q + 32'd4;   // natural 32-bit wrap
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      last_pc_q   <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      // Remember the visible pc so instr_pc holds once the FIFO runs dry.
      if (instr_valid) last_pc_q <= addr_q[rd_ptr_q];
      if (redirect_valid) begin
        infl_q   <= 1'b0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        infl_q <= issue;
        if (issue) infl_addr_q <= pc_q;
        if (push)  wr_ptr_q    <= wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_q    <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: cnt_q gates every read.
  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      data_q[wr_ptr_q] <= imem_rdata;
      addr_q[wr_ptr_q] <= infl_addr_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based transaction model.
module tb_instr_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr, instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0113;
      32'h4:   return 32'h00C0_0193;
      32'h8:   return 32'hFF71_8393;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Synchronous ROM: data appears the cycle after the strobe.
  always @(posedge clk) if (imem_en) imem_rdata <= rom(imem_addr);

  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc, m_last, m_iaddr;
  bit          m_infl;
  int          checks = 0, passes = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check settled outputs, then advance
  // the model on the rising edge.
  task automatic cycle(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc);
    bit e_en, e_vld;
    reset = !rst; instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    if (rst) begin
      q.delete(); m_infl = 0; m_pc = 32'h0; m_last = 32'h0; m_iaddr = 32'h0;
    end
    #1;
    e_vld = (q.size() != 0);
    e_en  = !rst && !rv && ((q.size() + int'(m_infl)) < DEPTH);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_vld});
    chk("instr", instr, e_vld ? q[0].data : NOP);
    chk("instr_pc", instr_pc, e_vld ? q[0].addr : m_last);
    chk("imem_en", {31'b0, imem_en}, {31'b0, e_en});
    if (e_en) chk("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    if (!rst) begin
      if (e_vld) m_last = q[0].addr;
      if (rv) begin
        q.delete(); m_infl = 0; m_pc = rpc & ~32'h3;
      end else begin
        if (e_vld && rdy) void'(q.pop_front());
        if (m_infl) q.push_back('{addr: m_iaddr, data: rom(m_iaddr)});
        m_infl = e_en;
        if (e_en) begin m_iaddr = m_pc; m_pc = m_pc + 32'd4; end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit rs, rd, rv;
    logic [31:0] rp;
    // reset state
    repeat (3) cycle(1, 1, 0, 0);
    // first fetches: 0,4,8 and 2-cycle fill latency
    repeat (8) cycle(0, 1, 0, 0);
    // decode stall: FIFO fills to DEPTH, head holds, then drains gap-free
    repeat (10) cycle(0, 0, 0, 0);
    repeat (8) cycle(0, 1, 0, 0);
    // redirect with 3 queued + 1 in flight
    repeat (6) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_0030);
    repeat (8) cycle(0, 1, 0, 0);
    // misaligned redirect target
    cycle(0, 1, 1, 32'h0000_0046);
    repeat (6) cycle(0, 1, 0, 0);
    // redirect coinciding with a handshake
    cycle(0, 1, 1, 32'h0000_0100);
    repeat (6) cycle(0, 1, 0, 0);
    // reset with FIFO full, held 2 cycles
    repeat (6) cycle(0, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0);
    repeat (6) cycle(0, 1, 0, 0);
    // fetch PC wrap past 32'hFFFF_FFFC
    cycle(0, 1, 1, 32'hFFFF_FFF4);
    repeat (8) cycle(0, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 500; i++) begin
      rs = ($urandom_range(99) == 0);
      rd = ($urandom_range(9) < 7);
      rv = ($urandom_range(19) == 0);
      rp = ($urandom_range(1) == 1) ? $urandom : (32'hFFFF_FFF0 + $urandom_range(15));
      cycle(rs, rd, rv, rp);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
